// File: rtl/demux_fluxo_pkg.sv
// demux_fluxo_pkg: default lane geometry shared by the demux and its decoder
package demux_fluxo_pkg;
   localparam int DEF_N_OUT  = 4;
   localparam int DEF_DATA_W = 1;
endpackage

// File: rtl/demux_fluxo_decoder.sv
// demux_decoder: select -> one-hot lane enable, all zero when select is out of range
module demux_decoder
   import demux_fluxo_pkg::*;
#(
   parameter  int N_OUT = DEF_N_OUT,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic [SEL_W-1:0] S,
   output logic [N_OUT-1:0] o_en
);
   for (genvar i = 0; i < N_OUT; i++) begin : g_en
      assign o_en[i] = S == SEL_W'(i);
   end
endmodule

// File: rtl/demux_fluxo.sv
// demux_fluxo: registered 1-to-N demux, D goes to lane S, all other lanes 0
module demux_fluxo
   import demux_fluxo_pkg::*;
#(
   parameter  int N_OUT  = DEF_N_OUT,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int SEL_W  = $clog2(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEL_W-1:0]        S,
   input  logic [DATA_W-1:0]       D,
   output logic [N_OUT*DATA_W-1:0] Y
);
   logic [N_OUT-1:0]        w_en;
   logic [N_OUT*DATA_W-1:0] w_y;
   demux_decoder #(.N_OUT(N_OUT)) u_dec (
      .S    (S),
      .o_en (w_en)
   );
   for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      assign w_y[i*DATA_W +: DATA_W] = {DATA_W{w_en[i]}} & D;
   end
   // register the steered lanes; reset clears every lane and overrides S/D
   always_ff @(posedge clk) begin
      if (!rst_n) Y <= '0;
      else        Y <= w_y;
   end
endmodule

// File: tb/tb_demux_fluxo.sv
// tb_demux_fluxo: directed checks of the default 1:4 demux and a 3-lane 4-bit variant
module tb_demux_fluxo;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [1:0]  s4 = 0;
   logic        d4 = 0;
   logic [3:0]  y4;
   logic [1:0]  s3 = 0;
   logic [3:0]  d3 = 0;
   logic [11:0] y3;
   int checks = 0;
   int errors = 0;
   logic prv_rst = 1;

   demux_fluxo dut4 (.clk(clk), .rst_n(rst_n), .S(s4), .D(d4), .Y(y4));
   demux_fluxo #(.N_OUT(3), .DATA_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .S(s3), .D(d3), .Y(y3));

   always #5 clk = ~clk;

   always @(posedge clk) prv_rst <= ~rst_n;

   // at most one active lane, and everything clear right after a reset edge
   always @(negedge clk) begin
      assert ($onehot0(y4)) else $error("FAIL onehot0 y4 got %b", y4);
      assert ($onehot0({|y3[11:8], |y3[7:4], |y3[3:0]})) else $error("FAIL onehot0 y3 got %h", y3);
      if (prv_rst) begin
         assert (y4 == 4'b0 && y3 == 12'h0) else $error("FAIL post-reset y4 %b y3 %h want 0", y4, y3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; d4 = 1; s4 = 2'b10;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (y4 !== 4'b0000) begin errors++; $display("FAIL reset[%0d] got %b want 0000", k, y4); end
      end
      checks++;
      if (y3 !== 12'h000) begin errors++; $display("FAIL reset3 got %h want 000", y3); end
      rst_n = 1;
      tick();
      checks++;
      if (y4 !== 4'b0100) begin errors++; $display("FAIL reset_release got %b want 0100", y4); end
   endtask

   task automatic test_walk();
      logic [3:0] exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [3:0] prev;
      d4 = 1;
      for (int i = 0; i < 4; i++) begin
         prev = y4;
         s4 = 2'(i);
         #1;
         checks++;
         if (y4 !== prev) begin errors++; $display("FAIL walk_lag[%0d] got %b want %b", i, y4, prev); end
         tick();
         checks++;
         if (y4 !== exp[i]) begin errors++; $display("FAIL walk[%0d] got %b want %b", i, y4, exp[i]); end
      end
   endtask

   task automatic test_zero();
      d4 = 0;
      for (int i = 0; i < 4; i++) begin
         s4 = 2'(i);
         tick();
         checks++;
         if (y4 !== 4'b0000) begin errors++; $display("FAIL zero[%0d] got %b want 0000", i, y4); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] sv [3] = '{2'd2, 2'd0, 2'd1};
      logic       dv [3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0] ev [3] = '{4'b0100, 4'b0001, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         s4 = sv[i]; d4 = dv[i];
         tick();
         checks++;
         if (y4 !== ev[i]) begin errors++; $display("FAIL b2b[%0d] got %b want %b", i, y4, ev[i]); end
      end
   endtask

   task automatic test_midstream_reset();
      d4 = 1; s4 = 2'b11;
      tick();
      checks++;
      if (y4 !== 4'b1000) begin errors++; $display("FAIL mid_pre got %b want 1000", y4); end
      rst_n = 0;
      tick();
      checks++;
      if (y4 !== 4'b0000) begin errors++; $display("FAIL mid_rst got %b want 0000", y4); end
      rst_n = 1;
      tick();
      checks++;
      if (y4 !== 4'b1000) begin errors++; $display("FAIL mid_post got %b want 1000", y4); end
   endtask

   task automatic test_param3();
      logic [1:0]  sv [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
      logic [3:0]  dv [4] = '{4'hF, 4'hF, 4'hA, 4'h5};
      logic [11:0] ev [4] = '{12'h000, 12'h0F0, 12'h00A, 12'h500};
      for (int i = 0; i < 4; i++) begin
         s3 = sv[i]; d3 = dv[i];
         tick();
         checks++;
         if (y3 !== ev[i]) begin errors++; $display("FAIL p3[%0d] got %h want %h", i, y3, ev[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_walk();
      test_zero();
      test_back_to_back();
      test_midstream_reset();
      test_param3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
